pmem_arbiter: RTL and testbench

Two-port arbiter sharing one physical-memory port between the instruction cache and the data cache of the split-cache LC-3b memory hierarchy. The arbiter takes line-sized (128-bit) miss traffic from each cache's pmem interface and grants the shared port to one requester at a time. It holds the grant until memory responds, and resolves simultaneous requests round-robin. It sits between the two cache_control/datapath pairs and the physical memory (or L2) model.

---
 rtl/pmem_arbiter.sv | 115 +++++++++++
 tb/tb_pmem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between icache and dcache.
// Optional perf counters (grants, conflicts) under `define PMEM_ARB_PERF_EN.
module pmem_arbiter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_pmem_read,
   input  logic [15:0]  i_pmem_address,
   output logic [127:0] i_pmem_rdata,
   output logic         i_pmem_resp,
   input  logic         d_pmem_read,
   input  logic         d_pmem_write,
   input  logic [15:0]  d_pmem_address,
   input  logic [127:0] d_pmem_wdata,
   output logic [127:0] d_pmem_rdata,
   output logic         d_pmem_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
`ifdef PMEM_ARB_PERF_EN
   input  logic         perf_clr,
   output logic [15:0]  perf_i_grants,
   output logic [15:0]  perf_d_grants,
   output logic [15:0]  perf_conflicts,
`endif
   input  logic         pmem_resp
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

   state_t state, state_n;
   logic   last_d;           // 1: last grant went to dcache
   logic   i_req, d_req;
   logic   gnt_i, gnt_d;

   assign i_req = i_pmem_read;
   assign d_req = d_pmem_read | d_pmem_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         last_d <= 1'b1;
      end else begin
         state <= state_n;
         if (gnt_i)      last_d <= 1'b0;
         else if (gnt_d) last_d <= 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      gnt_i   = 1'b0;
      gnt_d   = 1'b0;
      case (state)
         IDLE: begin
            // On a conflict, the side that did not win last time goes first.
            if (i_req && (!d_req || last_d)) gnt_i = 1'b1;
            else if (d_req)                  gnt_d = 1'b1;
            if (gnt_i)      state_n = SERVE_I;
            else if (gnt_d) state_n = SERVE_D;
         end
         SERVE_I, SERVE_D: if (pmem_resp) state_n = IDLE;
         default:          state_n = IDLE;
      endcase
   end

   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = 16'h0;
      pmem_wdata   = 128'h0;
      case (state)
         SERVE_I: begin
            pmem_read    = i_pmem_read;
            pmem_address = i_pmem_address;
         end
         SERVE_D: begin
            // Writeback wins if the dcache raises both commands.
            pmem_read    = d_pmem_read & ~d_pmem_write;
            pmem_write   = d_pmem_write;
            pmem_address = d_pmem_address;
            pmem_wdata   = d_pmem_wdata;
         end
         default: ;
      endcase
   end

   assign i_pmem_resp  = pmem_resp & (state == SERVE_I);
   assign d_pmem_resp  = pmem_resp & (state == SERVE_D);
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;

`ifdef PMEM_ARB_PERF_EN
   logic conflict;
   assign conflict = (state == IDLE) & i_req & d_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_i_grants  <= 16'h0;
         perf_d_grants  <= 16'h0;
         perf_conflicts <= 16'h0;
      end else if (perf_clr) begin
         perf_i_grants  <= 16'h0;
         perf_d_grants  <= 16'h0;
         perf_conflicts <= 16'h0;
      end else begin
         if (gnt_i && perf_i_grants != 16'hFFFF)     perf_i_grants  <= perf_i_grants + 16'd1;
         if (gnt_d && perf_d_grants != 16'hFFFF)     perf_d_grants  <= perf_d_grants + 16'd1;
         if (conflict && perf_conflicts != 16'hFFFF) perf_conflicts <= perf_conflicts + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized + directed bench for pmem_arbiter against a transaction-level model.
// Define PMEM_ARB_PERF_EN for both files to also exercise the perf counters.
module tb_pmem_arbiter;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         ir, dr, dw, mresp;
   logic [15:0]  ia, da;
   logic [127:0] wd, mrd;
   logic [127:0] i_rdata, d_rdata, p_wdata;
   logic         i_resp, d_resp, p_read, p_write;
   logic [15:0]  p_addr;
`ifdef PMEM_ARB_PERF_EN
   logic         perf_clr;
   logic [15:0]  perf_i, perf_d, perf_c;
`endif

   int checks = 0, failures = 0;
   int owner;      // 0 none, 1 icache, 2 dcache owns the shared port
   int last;       // 1 icache, 2 dcache
   int n_i, n_d, n_c;

   always #5 clk = ~clk;

   pmem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_pmem_read(ir), .i_pmem_address(ia), .i_pmem_rdata(i_rdata), .i_pmem_resp(i_resp),
      .d_pmem_read(dr), .d_pmem_write(dw), .d_pmem_address(da), .d_pmem_wdata(wd),
      .d_pmem_rdata(d_rdata), .d_pmem_resp(d_resp),
      .pmem_read(p_read), .pmem_write(p_write), .pmem_address(p_addr), .pmem_wdata(p_wdata),
      .pmem_rdata(mrd),
`ifdef PMEM_ARB_PERF_EN
      .perf_clr(perf_clr), .perf_i_grants(perf_i), .perf_d_grants(perf_d), .perf_conflicts(perf_c),
`endif
      .pmem_resp(mresp)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      owner = 0; last = 2; n_i = 0; n_d = 0; n_c = 0;
   endtask

   // Expected port behaviour given who owns the port and the current inputs.
   task automatic check_outputs();
      logic er, ew; logic [15:0] ea; logic [127:0] ewd;
      er = 0; ew = 0; ea = 0; ewd = 0;
      if (owner == 1) begin er = ir; ea = ia; end
      if (owner == 2) begin ew = dw; er = dr && !dw; ea = da; ewd = wd; end
      chk("pmem_read", p_read, er);
      chk("pmem_write", p_write, ew);
      chk("pmem_address", p_addr, ea);
      chk("pmem_wdata", p_wdata, ewd);
      chk("i_resp", i_resp, mresp && owner == 1);
      chk("d_resp", d_resp, mresp && owner == 2);
      chk("i_rdata", i_rdata, mrd);
      chk("d_rdata", d_rdata, mrd);
   endtask

   task automatic model_clock();
      bit iq, dq;
      iq = ir; dq = dr || dw;
      if (owner != 0) begin
         if (mresp) owner = 0;
      end else begin
         if (iq && dq) begin owner = (last == 1) ? 2 : 1; n_c++; end
         else if (iq) owner = 1;
         else if (dq) owner = 2;
         if (owner == 1) n_i++;
         if (owner == 2) n_d++;
         if (owner != 0) last = owner;
      end
   endtask

   // Called 1 time unit after a rising edge; leaves 1 unit after the next one.
   task automatic cycle(input logic i_r, input logic d_r, input logic d_w, input logic [15:0] i_a,
                        input logic [15:0] d_a, input logic [127:0] w, input logic r);
      ir = i_r; dr = d_r; dw = d_w; ia = i_a; da = d_a; wd = w; mresp = r;
      mrd = {$urandom, $urandom, $urandom, $urandom};
      #3;
      check_outputs();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic do_reset();
      ir = 0; dr = 0; dw = 0; ia = 0; da = 0; wd = 0; mresp = 0; mrd = 0;
      rst_n = 0;
      model_reset();
      #3;
      check_outputs();
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   initial begin
      rst_n = 1;
`ifdef PMEM_ARB_PERF_EN
      perf_clr = 0;
`endif
      @(posedge clk); #1;
      do_reset();

      // Lone icache read, memory answers in the third command cycle.
      cycle(1, 0, 0, 16'h0040, 0, 0, 0);
      cycle(1, 0, 0, 16'h0040, 0, 0, 0);
      cycle(1, 0, 0, 16'h0040, 0, 0, 0);
      ir = 1; mresp = 1; mrd = {32{4'hA, 4'h5}}; #3;
      chk("lone_i_resp", i_resp, 1'b1);
      chk("lone_i_data", i_rdata, {32{4'hA, 4'h5}});
      chk("lone_d_resp", d_resp, 1'b0);
      @(posedge clk); model_clock(); #1;
      cycle(0, 0, 0, 0, 0, 0, 0);

      // Conflict from reset: I, then D, then I.
      do_reset();
      for (int k = 0; k < 9; k++) cycle(1, 1, 0, 16'h0100, 16'h0200, 0, k % 3 == 2);
      chk("rr_owner_after3", p_read, 1'b0);

      // Simultaneous write+read from dcache: write wins.
      cycle(0, 1, 1, 0, 16'h1230, 128'hDEADBEEF_0123, 0);
      cycle(0, 1, 1, 0, 16'h1230, 128'hDEADBEEF_0123, 0);
      chk("wr_wins_write", p_write, 1'b1);
      cycle(0, 1, 1, 0, 16'h1230, 128'hDEADBEEF_0123, 1);

      // Writeback completes while icache waits; icache goes before dcache fill.
      do_reset();
      cycle(1, 0, 0, 16'h0300, 0, 0, 0);
      cycle(1, 0, 0, 16'h0300, 0, 0, 1);
      cycle(0, 0, 1, 0, 16'h0400, 128'h55, 0);
      cycle(1, 0, 1, 16'h0500, 16'h0400, 128'h55, 1);
      cycle(1, 1, 0, 16'h0500, 16'h0400, 0, 0);
      cycle(1, 1, 0, 16'h0500, 16'h0400, 0, 0);
      chk("wb_then_i_addr", p_addr, 16'h0500);
      cycle(1, 1, 0, 16'h0500, 16'h0400, 0, 1);
      cycle(1, 1, 0, 16'h0500, 16'h0400, 0, 0);
      cycle(1, 1, 0, 16'h0500, 16'h0400, 0, 1);

      // Reset in the middle of SERVE_D with memory responding.
      do_reset();
      cycle(0, 1, 0, 0, 16'h0600, 0, 0);
      cycle(0, 1, 0, 0, 16'h0600, 0, 0);
      mresp = 1; #1;
      rst_n = 0; model_reset(); #1;
      check_outputs();
      @(posedge clk); #1;
      check_outputs();
      rst_n = 1; mresp = 0;
      cycle(0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic, including pmem_resp while idle.
      for (int k = 0; k < 1500; k++)
         cycle($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
               16'($urandom), 16'($urandom), {$urandom, $urandom, $urandom, $urandom},
               $urandom_range(0, 2) == 0);

`ifdef PMEM_ARB_PERF_EN
      ir = 0; dr = 0; dw = 0; mresp = 0; #3;
      chk("perf_i", perf_i, 16'(n_i));
      chk("perf_d", perf_d, 16'(n_d));
      chk("perf_c", perf_c, 16'(n_c));
      perf_clr = 1; ir = 1; dr = 1;
      @(posedge clk); #1;
      perf_clr = 0; ir = 0; dr = 0;
      chk("perf_clr_i", perf_i, 16'h0);
      chk("perf_clr_d", perf_d, 16'h0);
      chk("perf_clr_c", perf_c, 16'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
